millisec_pulse_meter: RTL
=========================

Name: millisec_pulse_meter

Overview:
- Receive-side counterpart of the ms pulse generator in the timer directory. The generator produces a pulse lasting a programmed number of milliseconds; this block measures the high time of an incoming pulse and reports it in whole milliseconds.
- Used for loopback checks of timer outputs and for decoding ms-coded handshake pulses from external controllers.
- Input is asynchronous and is synchronised internally. The result is reported with a one-cycle valid strobe.

Parameters:
- CYCLES_PER_MS, 50000, clock cycles per millisecond (50 MHz clock); legal values are >= 2.
- COUNT_WIDTH, 8, width of the millisecond result.

Ports:
- iCLOCK50  input  1  system clock, 50 MHz.
- iRST  input  1  asynchronous active-high reset.
- iENABLE  input  1  arms measurement; low aborts or holds the block in IDLE.
- iPULSE  input  1  asynchronous pulse to be measured.
- oMILLISEC_COUNT  output  COUNT_WIDTH  last completed measurement, floor(high cycles / CYCLES_PER_MS), saturating.
- oVALID  output  1  one-cycle strobe when oMILLISEC_COUNT is updated.
- oOVERFLOW  output  1  result saturated; updated together with oVALID.
- oBUSY  output  1  high while a pulse is being measured.

Behaviour:
- Reset (async, active-high):
  - All state, counters and sync flops are cleared.
  - oMILLISEC_COUNT=0, oVALID=0, oOVERFLOW=0, oBUSY=0, FSM=IDLE.
- Input conditioning:
  - iPULSE passes through a 2-flop synchroniser to give s.
  - s_d is s delayed by one cycle.
  - rise = s & ~s_d; fall = ~s & s_d.
- Sub-ms counter: width ceil(log2(CYCLES_PER_MS)). ms counter: COUNT_WIDTH.
- FSM states: IDLE, MEASURE, DONE.
  - IDLE -> MEASURE: on rise with iENABLE=1. In the same edge, set sub=1 and ms=0, because the rise cycle counts as one high cycle.
  - MEASURE, each cycle with s=1 and iENABLE=1:
    - If sub==CYCLES_PER_MS-1: set sub=0 and ms=ms+1. If ms is already all-ones, ms holds and the sticky overflow is set.
    - Otherwise: sub=sub+1.
  - MEASURE -> DONE: on fall.
  - MEASURE -> IDLE: on iENABLE=0 (abort). No oVALID, and outputs keep their previous values.
  - DONE: load oMILLISEC_COUNT<=ms and oOVERFLOW<=overflow. oVALID is high for exactly this one cycle. Next state is IDLE unconditionally.
- Counting: the number of high cycles N is the number of cycles with s=1, starting at the rise cycle. Result = min(floor(N/CYCLES_PER_MS), 2^COUNT_WIDTH-1). Partial milliseconds are truncated.
- Latency:
  - A rising edge on iPULSE drives oBUSY high 3 clocks later (2 sync flops plus the edge register).
  - oVALID is asserted 1 clock after fall is detected.
- oBUSY is 1 only in MEASURE.
- oMILLISEC_COUNT and oOVERFLOW hold their value until the next oVALID.
- Boundary cases:
  - Pulse already high when iENABLE rises: ignored. The block waits for s to go low, then for the next rise.
  - Rise arriving during DONE: missed. The block only re-arms on a later rise. A back-to-back gap of at least 2 low cycles is guaranteed by sources.
  - N exactly k*CYCLES_PER_MS: result is k.
  - N = CYCLES_PER_MS-1: result is 0 and oVALID still pulses.
  - Pulse shorter than 1 synchronised cycle (glitch): may be unseen, and no response is required.
  - Pulse never falls: the block stays in MEASURE with ms saturated until fall, iENABLE=0, or reset.
  - iRST mid-measurement: immediate return to the reset state. No oVALID.
  - iENABLE dropping in the same cycle as fall: abort takes priority, so no oVALID.

Test Plan (CYCLES_PER_MS=10 unless stated):
- Reset, then iENABLE=1, iPULSE high for 35 clocks -> one oVALID, oMILLISEC_COUNT=3, oOVERFLOW=0. oBUSY is high for 35 clocks, starting 3 clocks after the iPULSE rise.
- iPULSE high for 10 clocks, then for 9 clocks (gap of 5 low) -> two oVALIDs with counts 1 then 0.
- COUNT_WIDTH=4, iPULSE high for 200 clocks -> oMILLISEC_COUNT=15, oOVERFLOW=1. A following 20-clock pulse gives count 2 and oOVERFLOW=0.
- iPULSE high before iENABLE rises, held for 40 clocks -> no oVALID. The next 30-clock pulse gives count 3.
- iENABLE dropped at clock 15 of a 40-clock pulse -> no oVALID, oBUSY falls the next clock, previous result held.
- iRST asserted at clock 20 of a 50-clock pulse -> all outputs 0 immediately, no oVALID. After release, a 10-clock pulse gives count 1.

Source files
------------

// File: rtl/millisec_pulse_meter.sv
// Measures the synchronised high time of iPULSE and reports it in whole milliseconds (saturating).
// Busy 3 clocks after the input rises; oVALID strobes one clock after the falling edge is seen.
module millisec_pulse_meter #(
  parameter int CYCLES_PER_MS = 50000,
  parameter int COUNT_WIDTH   = 8
) (
  input  logic                   iCLOCK50,
  input  logic                   iRST,
  input  logic                   iENABLE,
  input  logic                   iPULSE,
  output logic [COUNT_WIDTH-1:0] oMILLISEC_COUNT,
  output logic                   oVALID,
  output logic                   oOVERFLOW,
  output logic                   oBUSY
);

  localparam int SUB_W = (CYCLES_PER_MS > 1) ? $clog2(CYCLES_PER_MS) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CYCLES_PER_MS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_sync1;
  logic                   r_sync2;
  logic                   r_s_d;
  logic [SUB_W-1:0]       r_sub;
  logic [COUNT_WIDTH-1:0] r_ms;
  logic                   r_ovf;
  logic [COUNT_WIDTH-1:0] r_count;
  logic                   r_count_ovf;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_start;
  logic                   w_count_en;
  logic                   w_finish;

  assign w_rise = r_sync2 & ~r_s_d;
  assign w_fall = ~r_sync2 & r_s_d;

  always_ff @(posedge iCLOCK50 or posedge iRST) begin
    if (iRST) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_s_d   <= 1'b0;
    end else begin
      r_sync1 <= iPULSE;
      r_sync2 <= r_sync1;
      r_s_d   <= r_sync2;
    end
  end

  always_ff @(posedge iCLOCK50 or posedge iRST) begin
    if (iRST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Abort on iENABLE low outranks a coincident fall, so no result is published.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_count_en  = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rise && iENABLE) begin
          w_state_nxt = MEASURE;
          w_start     = 1'b1;
        end
      end
      MEASURE: begin
        if (!iENABLE) begin
          w_state_nxt = IDLE;
        end else if (w_fall) begin
          w_state_nxt = DONE;
          w_finish    = 1'b1;
        end else if (r_sync2) begin
          w_count_en  = 1'b1;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // The rise cycle itself is the first high cycle, hence sub starts at 1.
  always_ff @(posedge iCLOCK50 or posedge iRST) begin
    if (iRST) begin
      r_sub <= '0;
      r_ms  <= '0;
      r_ovf <= 1'b0;
    end else if (w_start) begin
      r_sub <= SUB_W'(1);
      r_ms  <= '0;
      r_ovf <= 1'b0;
    end else if (w_count_en) begin
      if (r_sub == SUB_LAST) begin
        r_sub <= '0;
        if (&r_ms) begin
          r_ovf <= 1'b1;
        end else begin
          r_ms <= r_ms + COUNT_WIDTH'(1);
        end
      end else begin
        r_sub <= r_sub + SUB_W'(1);
      end
    end
  end

  // Results are loaded on entry to DONE so they are stable while oVALID is high.
  always_ff @(posedge iCLOCK50 or posedge iRST) begin
    if (iRST) begin
      r_count     <= '0;
      r_count_ovf <= 1'b0;
    end else if (w_finish) begin
      r_count     <= r_ms;
      r_count_ovf <= r_ovf;
    end
  end

  assign oMILLISEC_COUNT = r_count;
  assign oOVERFLOW       = r_count_ovf;
  assign oVALID          = (r_state == DONE);
  assign oBUSY           = (r_state == MEASURE);

endmodule
